// File: rtl/ram_arbiter_if.sv
// CPU fetch/data ports and single-port RAM port as seen by the arbiter.
// The arbiter connects through the slave modport; the CPU and RAM side use the master modport.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              iren;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [31:0]       iload;

  logic              dren;
  logic [3:0]        dwen;
  logic [ADDR_W-1:0] daddr;
  logic [31:0]       dstore;
  logic              dwait;
  logic [31:0]       dload;

  logic              ram_ren;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_ready;

  modport slave (
    input  iren, iaddr, dren, dwen, daddr, dstore, ram_rdata, ram_ready,
    output iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output iren, iaddr, dren, dwen, daddr, dstore, ram_rdata, ram_ready,
    input  iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between fetch and data ports; data wins, fetch forced after I_STARVE_MAX data grants.
// Each access takes a grant cycle plus at least one RAM cycle; requesters see wait until their matching completion.
module ram_arbiter #(
  parameter int unsigned I_STARVE_MAX = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input logic           clk,
  input logic           rst,
  ram_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, ACCESS} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  localparam int unsigned    CW         = 4;
  localparam logic [CW-1:0]  STARVE_MAX = CW'(I_STARVE_MAX);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [3:0]        wen_q,   wen_d;
  logic              ren_q,   ren_d;
  logic              dren_q,  dren_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CW-1:0]     starve_q, starve_d;

  logic              dreq;
  logic              d_write;
  logic              fetch_forced;
  logic              complete;
  logic              i_done;
  logic              d_done;
  logic [ADDR_W-1:0] iword;
  logic [ADDR_W-1:0] dword;
  logic              unused_lo;

  assign dreq         = bus.dren | (|bus.dwen);
  assign d_write      = |bus.dwen;
  assign iword        = {bus.iaddr[ADDR_W-1:2], 2'b00};
  assign dword        = {bus.daddr[ADDR_W-1:2], 2'b00};
  assign fetch_forced = bus.iren && (starve_q == STARVE_MAX);
  assign complete     = (state_q == ACCESS) && bus.ram_ready;
  assign unused_lo    = ^{bus.iaddr[1:0], bus.daddr[1:0]};

  // A completion only reaches a requester still asking for exactly what was issued.
  assign i_done = complete && (owner_q == OWN_I) && bus.iren &&
                  (iword == addr_q);
  assign d_done = complete && (owner_q == OWN_D) && dreq &&
                  (dword == addr_q) && (bus.dwen == wen_q) && (bus.dren == dren_q);

  assign bus.iwait     = bus.iren & ~i_done;
  assign bus.dwait     = dreq & ~d_done;
  assign bus.iload     = i_done ? bus.ram_rdata : 32'h0;
  assign bus.dload     = d_done ? bus.ram_rdata : 32'h0;

  assign bus.ram_ren   = ren_q;
  assign bus.ram_wen   = wen_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    ren_d    = ren_q;
    dren_d   = dren_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;

    case (state_q)
      IDLE: begin
        if (dreq && !fetch_forced) begin
          state_d = ACCESS;
          owner_d = OWN_D;
          addr_d  = dword;
          wen_d   = bus.dwen;
          ren_d   = ~d_write;
          dren_d  = bus.dren;
          wdata_d = bus.dstore;
          if (bus.iren) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end else if (bus.iren) begin
          state_d  = ACCESS;
          owner_d  = OWN_I;
          addr_d   = iword;
          wen_d    = 4'h0;
          ren_d    = 1'b1;
          dren_d   = 1'b0;
          wdata_d  = 32'h0;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      ACCESS: begin
        if (bus.ram_ready) begin
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 4'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      addr_q   <= '0;
      wen_q    <= 4'h0;
      ren_q    <= 1'b0;
      dren_q   <= 1'b0;
      wdata_q  <= 32'h0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      dren_q   <= dren_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_ram_arbiter;
  localparam int SMAX = 4;
  localparam int AW   = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(AW)) bus();
  ram_arbiter #(.I_STARVE_MAX(SMAX), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at most one transaction in flight, plus a count of data grants fetch has sat through.
  bit              m_busy, m_isd, m_ren, m_dren;
  logic [3:0]      m_wen;
  logic [AW-1:0]   m_addr;
  logic [31:0]     m_wdata;
  int              m_skip;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0;
      m_skip <= 0;
    end else if (m_busy) begin
      if (bus.ram_ready) m_busy <= 0;
    end else if ((bus.dren || bus.dwen != 0) && !(bus.iren && m_skip == SMAX)) begin
      m_busy  <= 1;
      m_isd   <= 1;
      m_addr  <= bus.daddr & ~32'h3;
      m_wen   <= bus.dwen;
      m_ren   <= (bus.dwen == 0);
      m_dren  <= bus.dren;
      m_wdata <= bus.dstore;
      m_skip  <= bus.iren ? ((m_skip < SMAX) ? m_skip + 1 : SMAX) : 0;
    end else if (bus.iren) begin
      m_busy <= 1;
      m_isd  <= 0;
      m_addr <= bus.iaddr & ~32'h3;
      m_wen  <= 4'h0;
      m_ren  <= 1;
      m_skip <= 0;
    end else begin
      m_skip <= 0;
    end
  end

  bit e_cmp, e_idone, e_ddone, e_dq;
  always @(negedge clk) begin
    e_dq    = bus.dren || (bus.dwen != 0);
    e_cmp   = m_busy && bus.ram_ready;
    e_idone = e_cmp && !m_isd && bus.iren && ((bus.iaddr & ~32'h3) == m_addr);
    e_ddone = e_cmp && m_isd && e_dq && ((bus.daddr & ~32'h3) == m_addr) &&
              (bus.dwen == m_wen) && (bus.dren == m_dren);
    chk("m_ram_ren", bus.ram_ren, m_busy && m_ren);
    chk("m_ram_wen", bus.ram_wen, m_busy ? m_wen : 4'h0);
    if (m_busy) begin
      chk("m_ram_addr", bus.ram_addr, m_addr);
      if (m_wen != 0) chk("m_ram_wdata", bus.ram_wdata, m_wdata);
    end
    chk("m_iwait", bus.iwait, bus.iren && !e_idone);
    chk("m_dwait", bus.dwait, e_dq && !e_ddone);
    if (e_idone) chk("m_iload", bus.iload, bus.ram_rdata);
    if (e_ddone) chk("m_dload", bus.dload, bus.ram_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iren = 0; bus.iaddr = '0; bus.dren = 0; bus.dwen = '0;
    bus.daddr = '0; bus.dstore = '0; bus.ram_ready = 0; bus.ram_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    rst = 0;
  endtask

  logic [AW-1:0] grant_addr [6];
  logic          i_fin, d_fin;

  initial begin
    // Reset values with a fetch already requested, then a single fetch
    rst = 1;
    idle_inputs();
    bus.iren = 1; bus.iaddr = 32'h100;
    @(negedge clk);
    chk("rst_ram_ren", bus.ram_ren, 1'b0);
    chk("rst_ram_wen", bus.ram_wen, 4'h0);
    chk("rst_ram_addr", bus.ram_addr, 32'h0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'h0);
    chk("rst_iwait", bus.iwait, 1'b1);
    chk("rst_dwait", bus.dwait, 1'b0);
    chk("rst_iload", bus.iload, 32'h0);
    chk("rst_dload", bus.dload, 32'h0);
    tick(); rst = 0;
    @(negedge clk);
    chk("a_idle_ren", bus.ram_ren, 1'b0);
    tick();
    bus.ram_ready = 1; bus.ram_rdata = 32'h13;
    @(negedge clk);
    chk("a_ren", bus.ram_ren, 1'b1);
    chk("a_addr", bus.ram_addr, 32'h100);
    chk("a_iwait", bus.iwait, 1'b0);
    chk("a_iload", bus.iload, 32'h13);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("a_steady_ren", bus.ram_ren, (k % 2) == 1);
      chk("a_steady_iwait", bus.iwait, (k % 2) == 0);
    end

    // Simultaneous fetch and write: data first, fetch in the next IDLE
    do_reset();
    bus.iren = 1; bus.iaddr = 32'h100;
    bus.dwen = 4'b0011; bus.daddr = 32'h203; bus.dstore = 32'h0000BEEF;
    tick();
    bus.ram_ready = 1; bus.ram_rdata = 32'h1234;
    @(negedge clk);
    chk("b_wen", bus.ram_wen, 4'b0011);
    chk("b_ren", bus.ram_ren, 1'b0);
    chk("b_addr", bus.ram_addr, 32'h200);
    chk("b_wdata", bus.ram_wdata, 32'h0000BEEF);
    chk("b_dwait", bus.dwait, 1'b0);
    chk("b_iwait", bus.iwait, 1'b1);
    tick();
    bus.dwen = 4'h0; bus.ram_ready = 0;
    @(negedge clk);
    chk("b_idle_wen", bus.ram_wen, 4'h0);
    tick();
    @(negedge clk);
    chk("b_i_ren", bus.ram_ren, 1'b1);
    chk("b_i_addr", bus.ram_addr, 32'h100);

    // Starvation bound: D,D,D,D,I,D
    do_reset();
    bus.iren = 1; bus.iaddr = 32'h100;
    bus.dren = 1; bus.daddr = 32'h800;
    bus.ram_ready = 1; bus.ram_rdata = 32'h77;
    grant_addr = '{32'h800, 32'h800, 32'h800, 32'h800, 32'h100, 32'h800};
    for (int g = 0; g < 6; g++) begin
      tick();
      @(negedge clk);
      chk("c_grant_addr", bus.ram_addr, grant_addr[g]);
      tick();
    end

    // Fetch redirect while the old fetch is in flight
    do_reset();
    bus.iren = 1; bus.iaddr = 32'h100;
    tick();
    @(negedge clk);
    chk("d_addr_old", bus.ram_addr, 32'h100);
    tick();
    bus.iaddr = 32'h400; bus.ram_ready = 1; bus.ram_rdata = 32'hAAAA;
    @(negedge clk);
    chk("d_discard_iwait", bus.iwait, 1'b1);
    tick();
    bus.ram_ready = 0;
    @(negedge clk);
    chk("d_idle_ren", bus.ram_ren, 1'b0);
    tick();
    bus.ram_ready = 1; bus.ram_rdata = 32'h55;
    @(negedge clk);
    chk("d_addr_new", bus.ram_addr, 32'h400);
    chk("d_iwait", bus.iwait, 1'b0);
    chk("d_iload", bus.iload, 32'h55);

    // Reset in the middle of a write access, then re-issue
    do_reset();
    bus.iren = 1; bus.iaddr = 32'h300;
    bus.dwen = 4'hF; bus.daddr = 32'h40; bus.dstore = 32'hA5A5A5A5;
    tick();
    @(negedge clk);
    chk("e_wen", bus.ram_wen, 4'hF);
    #1 rst = 1;
    #1;
    chk("e_rst_wen", bus.ram_wen, 4'h0);
    chk("e_rst_ren", bus.ram_ren, 1'b0);
    chk("e_rst_dwait", bus.dwait, 1'b1);
    chk("e_rst_iwait", bus.iwait, 1'b1);
    tick(); rst = 0;
    tick();
    @(negedge clk);
    chk("e_reissue_wen", bus.ram_wen, 4'hF);
    chk("e_reissue_addr", bus.ram_addr, 32'h40);

    // Read+write request with a three-cycle RAM
    do_reset();
    bus.dren = 1; bus.dwen = 4'hF; bus.daddr = 32'h10; bus.dstore = 32'h12345678;
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.ram_ready = (k == 2); bus.ram_rdata = 32'hCAFE0000 + k;
      @(negedge clk);
      chk("f_wen", bus.ram_wen, 4'hF);
      chk("f_ren", bus.ram_ren, 1'b0);
      chk("f_dwait", bus.dwait, k != 2);
      if (k == 2) chk("f_dload", bus.dload, 32'hCAFE0002);
      if (k < 2) tick();
    end
    tick();
    bus.dren = 0; bus.dwen = 0; bus.ram_ready = 0;
    @(negedge clk);
    chk("f_idle_wen", bus.ram_wen, 4'h0);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      i_fin = bus.iren && !bus.iwait;
      d_fin = (bus.dren || bus.dwen != 0) && !bus.dwait;
      tick();
      rst = (c == 1500);
      bus.ram_ready = ($urandom_range(0, 2) != 0);
      bus.ram_rdata = $urandom;
      if (!bus.iren || i_fin) begin
        bus.iren  = ($urandom_range(0, 3) != 0);
        bus.iaddr = AW'($urandom_range(0, 255));
      end else if ($urandom_range(0, 19) == 0) begin
        bus.iaddr = AW'($urandom_range(0, 255));
      end
      if (!(bus.dren || bus.dwen != 0) || d_fin) begin
        case ($urandom_range(0, 3))
          0:       begin bus.dren = 0; bus.dwen = 4'h0; end
          1:       begin bus.dren = 1; bus.dwen = 4'h0; end
          2:       begin bus.dren = 0; bus.dwen = 4'($urandom_range(1, 15)); end
          default: begin bus.dren = 1; bus.dwen = 4'($urandom_range(1, 15)); end
        endcase
        bus.daddr  = AW'($urandom_range(0, 255));
        bus.dstore = $urandom;
      end else if ($urandom_range(0, 29) == 0) begin
        bus.daddr = AW'($urandom_range(0, 255));
      end
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
